// File: rtl/mac_hidden_seq.sv
// Hidden-layer MAC sequencer: walks every input of every hidden neuron,
// accumulates weight x activation, then rescales, saturates and streams
// one result per neuron on a valid/ready interface.
// Optional build macro: MAC_HIDDEN_RELU_EN (clamps negative results to 0).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start
// ISSUE   | one weight/activation read per cycle, N_IN cycles per neuron
// DRAIN   | waiting for the last read data to reach the accumulator
// OUT     | result presented, holding until downstream accepts
// DONE    | one-cycle done pulse, then back to IDLE
module mac_hidden_seq #(
  parameter int DATA_W    = 16,
  parameter int N_IN      = 128,
  parameter int N_HIDDEN  = 64,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 2*DATA_W + $clog2(N_IN)
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    start,
  output logic                                                    busy,
  output logic                                                    done,
  output logic [$clog2((N_HIDDEN*N_IN > 1) ? N_HIDDEN*N_IN : 2)-1:0] w_raddr,
  input  logic [DATA_W-1:0]                                       w_rdata,
  output logic [$clog2((N_IN > 1) ? N_IN : 2)-1:0]                 x_raddr,
  input  logic [DATA_W-1:0]                                       x_rdata,
  output logic                                                    h_valid,
  input  logic                                                    h_ready,
  output logic [$clog2((N_HIDDEN > 1) ? N_HIDDEN : 2)-1:0]         h_idx,
  output logic [DATA_W-1:0]                                       h_data
);

  localparam int AW = $clog2((N_HIDDEN*N_IN > 1) ? N_HIDDEN*N_IN : 2);
  localparam int XW = $clog2((N_IN > 1) ? N_IN : 2);
  localparam int HW = $clog2((N_HIDDEN > 1) ? N_HIDDEN : 2);
  localparam int PW = 2*DATA_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [XW-1:0]            i_cnt;
  logic [HW-1:0]            h_cnt;
  logic [AW-1:0]            base;
  logic                     rd_vld;
  logic                     rd_vld_d;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  acc_shift;
  logic signed [PW-1:0]     prod;
  logic signed [DATA_W-1:0] sat_val;
  logic signed [DATA_W-1:0] res_val;
  logic                     last_i;
  logic                     last_h;

  assign last_i = (i_cnt == XW'(N_IN-1));
  assign last_h = (h_cnt == HW'(N_HIDDEN-1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; DRAIN leaves once the address stage of the read pipe is empty.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: if (last_i) state_nxt = S_DRAIN;
      S_DRAIN: if (!rd_vld) state_nxt = S_OUT;
      S_OUT:   if (h_ready) state_nxt = last_h ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Product, accumulator look-ahead (includes the product landing this cycle),
  // rescale, saturation and optional ReLU.
  always_comb begin
    prod      = $signed(w_rdata) * $signed(x_rdata);
    acc_nxt   = rd_vld_d ? (acc + ACC_W'(prod)) : acc;
    acc_shift = acc_nxt >>> FRAC_BITS;
    if (acc_shift > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
    else if (acc_shift < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
    else                          sat_val = acc_shift[DATA_W-1:0];
`ifdef MAC_HIDDEN_RELU_EN
    res_val = sat_val[DATA_W-1] ? '0 : sat_val;
`else
    res_val = sat_val;
`endif
  end

  // Counters, address registers, read-valid pipe, accumulator and output stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      w_raddr  <= '0;
      x_raddr  <= '0;
      h_valid  <= 1'b0;
      h_idx    <= '0;
      h_data   <= '0;
      i_cnt    <= '0;
      h_cnt    <= '0;
      base     <= '0;
      rd_vld   <= 1'b0;
      rd_vld_d <= 1'b0;
      acc      <= '0;
    end else begin
      rd_vld   <= (state == S_ISSUE);
      rd_vld_d <= rd_vld;
      acc      <= acc_nxt;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            i_cnt <= '0;
            h_cnt <= '0;
            base  <= '0;
            acc   <= '0;
          end
        end
        S_ISSUE: begin
          w_raddr <= base + AW'(i_cnt);
          x_raddr <= i_cnt;
          i_cnt   <= last_i ? '0 : i_cnt + XW'(1);
        end
        S_DRAIN: begin
          if (!rd_vld) begin
            h_data  <= res_val;
            h_idx   <= h_cnt;
            h_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (h_ready) begin
            h_valid <= 1'b0;
            acc     <= '0;
            if (last_h) begin
              done <= 1'b1;
              busy <= 1'b0;
            end else begin
              h_cnt <= h_cnt + HW'(1);
              i_cnt <= '0;
              base  <= base + AW'(N_IN);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_hidden_seq.sv
// Directed bench for mac_hidden_seq with N_IN=4, N_HIDDEN=2.
// u_dut uses FRAC_BITS=0, u_dut8 uses FRAC_BITS=8; both read the same
// weight/activation tables through their own 1-cycle synchronous read models.
module tb_mac_hidden_seq;

`ifdef MAC_HIDDEN_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, start8;
  logic               busy, done, busy8, done8;
  logic [2:0]         w_raddr, w_raddr8;
  logic [1:0]         x_raddr, x_raddr8;
  logic signed [15:0] w_rdata, x_rdata, w_rdata8, x_rdata8;
  logic               h_valid, h_valid8;
  logic               h_ready, h_ready8;
  logic [0:0]         h_idx, h_idx8;
  logic signed [15:0] h_data, h_data8;

  logic signed [15:0] wmem [8];
  logic signed [15:0] xmem [4];

  int n_cmp = 0;
  int n_err = 0;

  int n_res, first_v, done_cyc;
  int res_idx [8];
  int res_data [8];

  logic               sel8;
  logic               obs_valid, obs_done;
  logic [0:0]         obs_idx;
  logic signed [15:0] obs_data;

  assign obs_valid = sel8 ? h_valid8 : h_valid;
  assign obs_done  = sel8 ? done8    : done;
  assign obs_idx   = sel8 ? h_idx8   : h_idx;
  assign obs_data  = sel8 ? h_data8  : h_data;

  always #5 clk = ~clk;

  mac_hidden_seq #(.DATA_W(16), .N_IN(4), .N_HIDDEN(2), .FRAC_BITS(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .w_raddr(w_raddr), .w_rdata(w_rdata), .x_raddr(x_raddr), .x_rdata(x_rdata),
    .h_valid(h_valid), .h_ready(h_ready), .h_idx(h_idx), .h_data(h_data)
  );

  mac_hidden_seq #(.DATA_W(16), .N_IN(4), .N_HIDDEN(2), .FRAC_BITS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .done(done8),
    .w_raddr(w_raddr8), .w_rdata(w_rdata8), .x_raddr(x_raddr8), .x_rdata(x_rdata8),
    .h_valid(h_valid8), .h_ready(h_ready8), .h_idx(h_idx8), .h_data(h_data8)
  );

  // Synchronous read memories, 1-cycle latency.
  always @(posedge clk) begin
    w_rdata  <= wmem[w_raddr];
    x_rdata  <= xmem[x_raddr];
    w_rdata8 <= wmem[w_raddr8];
    x_rdata8 <= xmem[x_raddr8];
  end

  task automatic check_val(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int relu_exp(input int v);
    return (RELU && v < 0) ? 0 : v;
  endfunction

  // One full pass with h_ready high; records results, first-valid and done cycles.
  // Cycle 1 is the clock edge that samples start. dup_at re-pulses start mid-pass.
  task automatic run_pass(input bit use8, input int dup_at);
    n_res    = 0;
    first_v  = 0;
    done_cyc = 0;
    sel8     = use8;
    @(negedge clk);
    if (use8) start8 = 1'b1;
    else      start  = 1'b1;
    for (int c = 1; c <= 200 && done_cyc == 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      start  = (!use8 && c == dup_at);
      if (obs_valid) begin
        if (first_v == 0) first_v = c;
        if (n_res < 8) begin
          res_idx[n_res]  = int'(obs_idx);
          res_data[n_res] = int'(obs_data);
        end
        n_res++;
      end
      if (obs_done) done_cyc = c;
    end
    start = 1'b0;
    check_val("pass_done_seen", int'(done_cyc != 0), 1);
  endtask

  initial begin
    int hold_idx, hold_data, hold_w, hold_x, stray;

    rst_n = 1'b0; start = 1'b0; start8 = 1'b0;
    h_ready = 1'b1; h_ready8 = 1'b1; sel8 = 1'b0;
    wmem = '{16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1};
    xmem = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};

    // Reset values.
    repeat (3) @(negedge clk);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_h_valid", int'(h_valid), 0);
    check_val("rst_w_raddr", int'(w_raddr), 0);
    check_val("rst_x_raddr", int'(x_raddr), 0);
    check_val("rst_h_idx", int'(h_idx), 0);
    check_val("rst_h_data", int'(h_data), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic pass: sum 1+2+3+4 per neuron; valid at cycle N_IN+3, done at 2*7+1.
    run_pass(1'b0, 0);
    check_val("basic_n_res", n_res, 2);
    check_val("basic_first_valid_cyc", first_v, 7);
    check_val("basic_done_cyc", done_cyc, 15);
    check_val("basic_idx0", res_idx[0], 0);
    check_val("basic_data0", res_data[0], 10);
    check_val("basic_idx1", res_idx[1], 1);
    check_val("basic_data1", res_data[1], 10);
    @(negedge clk);
    check_val("basic_busy_after", int'(busy), 0);

    // Mixed signs: 10-12-2+0 = -4.
    wmem = '{16'sd2, -16'sd3, 16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd1};
    xmem = '{16'sd5, 16'sd4, -16'sd2, 16'sd7};
    run_pass(1'b0, 0);
    check_val("neg_data0", res_data[0], relu_exp(-4));
    check_val("neg_data1", res_data[1], 7);

    // Saturation both ways.
    wmem = '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767,
             -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768};
    xmem = '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767};
    run_pass(1'b0, 0);
    check_val("sat_pos", res_data[0], 32767);
    check_val("sat_neg", res_data[1], relu_exp(-32768));

    // Backpressure: hold h_ready low 5 cycles on neuron 0.
    wmem = '{16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1};
    xmem = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
    sel8 = 1'b0;
    h_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 50 && !h_valid; c++) @(negedge clk);
    check_val("bp_valid_seen", int'(h_valid), 1);
    hold_idx = int'(h_idx); hold_data = int'(h_data);
    hold_w = int'(w_raddr); hold_x = int'(x_raddr);
    check_val("bp_data", hold_data, 10);
    check_val("bp_w_raddr_last", hold_w, 3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_val("bp_hold_valid", int'(h_valid), 1);
      check_val("bp_hold_idx", int'(h_idx), hold_idx);
      check_val("bp_hold_data", int'(h_data), hold_data);
      check_val("bp_hold_w_raddr", int'(w_raddr), hold_w);
      check_val("bp_hold_x_raddr", int'(x_raddr), hold_x);
    end
    h_ready = 1'b1;
    @(negedge clk);
    check_val("bp_valid_dropped", int'(h_valid), 0);
    @(negedge clk);
    check_val("bp_next_w_raddr", int'(w_raddr), 4);
    check_val("bp_next_x_raddr", int'(x_raddr), 0);
    n_res = 0; done_cyc = 0;
    for (int c = 0; c < 50 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (h_valid) begin
        if (n_res == 0) begin
          res_idx[0] = int'(h_idx); res_data[0] = int'(h_data);
        end
        n_res++;
      end
      if (done) done_cyc = 1;
    end
    check_val("bp_done_seen", done_cyc, 1);
    check_val("bp_n1_count", n_res, 1);
    check_val("bp_n1_idx", res_idx[0], 1);
    check_val("bp_n1_data", res_data[0], 10);

    // start while busy is ignored.
    run_pass(1'b0, 4);
    check_val("dup_n_res", n_res, 2);
    check_val("dup_done_cyc", done_cyc, 15);
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy || h_valid) stray++;
    end
    check_val("dup_no_second_pass", stray, 0);

    // Reset mid-ISSUE of neuron 1.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check_val("abort_in_n1_busy", int'(busy), 1);
    check_val("abort_in_n1_w_raddr_nz", int'(w_raddr != 0), 1);
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_h_valid", int'(h_valid), 0);
    check_val("abort_w_raddr", int'(w_raddr), 0);
    check_val("abort_x_raddr", int'(x_raddr), 0);
    check_val("abort_h_data", int'(h_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (h_valid || done || busy) stray++;
    end
    check_val("abort_quiet_after", stray, 0);

    // FRAC_BITS=8: 640>>>8 = 2, -384>>>8 = -2 (floor).
    wmem = '{16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd0, 16'sd0, -16'sd2, -16'sd1};
    xmem = '{16'sd160, 16'sd160, 16'sd64, 16'sd256};
    run_pass(1'b1, 0);
    check_val("frac_n_res", n_res, 2);
    check_val("frac_pos", res_data[0], 2);
    check_val("frac_neg_floor", res_data[1], relu_exp(-2));
    check_val("frac_done_cyc", done_cyc, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
